// File: rtl/uart6551_tx_sched.sv
// ---------------------------------------------------------------------------
// uart6551_tx_sched
//
// Write scheduler that sits in front of a 6551-style UART transmitter. It
// merges three sources of traffic into the transmitter's write port:
//   - timed break requests (highest priority)
//   - XON/XOFF software flow-control characters
//   - host data bytes (lowest priority)
// Every write is spaced IDLE -> WR -> GAP -> IDLE, so consecutive tx_wr
// rising edges are always at least three cycles apart. This spacing lets the
// transmitter's write edge detector see every write.
//
// Ports
//   clk           clock; the only clock
//   rst           asynchronous, active-high reset
//   baud16x_ce    baud x16 clock enable; times the break
//   sw_flow_en    enables XON/XOFF flow control
//   rx_xoff_seen  one-cycle pulse: the remote end sent XOFF
//   rx_xon_seen   one-cycle pulse: the remote end sent XON
//   rx_hi         local receive FIFO is above its high watermark
//   rx_lo         local receive FIFO is below its low watermark
//   h_valid       host byte valid
//   h_data        host byte
//   h_ready       host byte accepted when h_valid & h_ready
//   brk_req       one-cycle pulse: request a timed break
//   brk_busy      a break is pending or in progress
//   tx_wr         write strobe to the transmitter (one cycle wide)
//   tx_din        byte to the transmitter; stable through WR and GAP
//   tx_full       transmitter FIFO full
//   tx_empty      transmitter FIFO empty
//   txBreak       break control to the transmitter
//   paused        remote XOFF in effect; host traffic is held off
//   xoff_sent     local XOFF sent and not yet cancelled by an XON
// ---------------------------------------------------------------------------
module uart6551_tx_sched #(
  parameter logic [7:0]  XON_CHAR  = 8'h11,
  parameter logic [7:0]  XOFF_CHAR = 8'h13,
  parameter logic [15:0] BRK_LEN   = 16'd160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud16x_ce,
  input  logic       sw_flow_en,
  input  logic       rx_xoff_seen,
  input  logic       rx_xon_seen,
  input  logic       rx_hi,
  input  logic       rx_lo,
  input  logic       h_valid,
  input  logic [7:0] h_data,
  output logic       h_ready,
  input  logic       brk_req,
  output logic       brk_busy,
  output logic       tx_wr,
  output logic [7:0] tx_din,
  input  logic       tx_full,
  input  logic       tx_empty,
  output logic       txBreak,
  output logic       paused,
  output logic       xoff_sent
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    GAP,
    BRK_DRAIN,
    BRK
  } state_e;

  // A zero-length break still lasts one tick: the terminal count is 0.
  localparam logic [15:0] BRK_LAST = (BRK_LEN == 16'd0) ? 16'd0 : (BRK_LEN - 16'd1);

  state_e      state_q,     state_d;
  logic        tx_wr_q,     tx_wr_d;
  logic [7:0]  tx_din_q,    tx_din_d;
  logic        txbreak_q,   txbreak_d;
  logic        paused_q,    paused_d;
  logic        xoff_sent_q, xoff_sent_d;
  logic        pend_xon_q,  pend_xon_d;
  logic        pend_xoff_q, pend_xoff_d;
  logic        brk_pend_q,  brk_pend_d;
  logic [15:0] brk_cnt_q,   brk_cnt_d;

  logic in_idle;
  logic ctrl_go;
  logic host_go;

  assign in_idle = (state_q == IDLE);

  // Host handshake is blocked by anything that outranks it or would stall it.
  assign h_ready = in_idle & ~tx_full & ~paused_q & ~brk_pend_q
                 & ~pend_xon_q & ~pend_xoff_q;

  assign brk_busy = brk_pend_q | (state_q == BRK_DRAIN) | (state_q == BRK);

  // Control characters bypass the remote pause: the remote end must still
  // hear our XOFF/XON even while it has paused us.
  assign ctrl_go = in_idle & ~brk_pend_q & sw_flow_en & ~tx_full
                 & (pend_xon_q | pend_xoff_q);

  assign host_go = h_valid & h_ready;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    tx_din_d    = tx_din_q;
    paused_d    = paused_q;
    xoff_sent_d = xoff_sent_q;
    pend_xon_d  = pend_xon_q;
    pend_xoff_d = pend_xoff_q;
    brk_pend_d  = brk_pend_q;
    brk_cnt_d   = brk_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (brk_pend_q) begin
          state_d = BRK_DRAIN;
        end else if (ctrl_go) begin
          // Only one of the two pending flags can be set at a time.
          tx_din_d    = pend_xoff_q ? XOFF_CHAR : XON_CHAR;
          xoff_sent_d = pend_xoff_q;
          state_d     = WR;
        end else if (host_go) begin
          tx_din_d = h_data;
          state_d  = WR;
        end
      end

      WR:  state_d = GAP;

      GAP: state_d = IDLE;

      BRK_DRAIN: begin
        // Let the transmitter finish shifting out queued bytes first.
        if (tx_empty) begin
          state_d   = BRK;
          brk_cnt_d = 16'd0;
        end
      end

      BRK: begin
        if (baud16x_ce) begin
          if (brk_cnt_q == BRK_LAST) begin
            state_d    = IDLE;
            brk_pend_d = 1'b0;
          end else begin
            brk_cnt_d = brk_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Flow-control requests: a new request overwrites the pending one.
    if (sw_flow_en && rx_hi && !xoff_sent_q) begin
      pend_xoff_d = 1'b1;
      pend_xon_d  = 1'b0;
    end else if (sw_flow_en && rx_lo && xoff_sent_q) begin
      pend_xon_d  = 1'b1;
      pend_xoff_d = 1'b0;
    end

    // Issuing a character retires its request on the same edge it enters WR.
    if (ctrl_go) begin
      pend_xon_d  = 1'b0;
      pend_xoff_d = 1'b0;
    end

    // Simultaneous XON and XOFF from the remote cancel out.
    if (sw_flow_en) begin
      if (rx_xoff_seen && !rx_xon_seen) begin
        paused_d = 1'b1;
      end else if (rx_xon_seen && !rx_xoff_seen) begin
        paused_d = 1'b0;
      end
    end

    // A break request while one is already outstanding is dropped.
    if (brk_req && !brk_busy) begin
      brk_pend_d = 1'b1;
    end

    // Disabling flow control forgets all flow state but leaves any write or
    // break already under way to complete.
    if (!sw_flow_en) begin
      paused_d    = 1'b0;
      xoff_sent_d = 1'b0;
      pend_xon_d  = 1'b0;
      pend_xoff_d = 1'b0;
    end

    // Strobe outputs are registered from the next state so they are clean.
    tx_wr_d   = (state_d == WR);
    txbreak_d = (state_d == BRK);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_wr_q     <= 1'b0;
      tx_din_q    <= 8'h00;
      txbreak_q   <= 1'b0;
      paused_q    <= 1'b0;
      xoff_sent_q <= 1'b0;
      pend_xon_q  <= 1'b0;
      pend_xoff_q <= 1'b0;
      brk_pend_q  <= 1'b0;
      brk_cnt_q   <= 16'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      tx_wr_q     <= tx_wr_d;
      tx_din_q    <= tx_din_d;
      txbreak_q   <= txbreak_d;
      paused_q    <= paused_d;
      xoff_sent_q <= xoff_sent_d;
      pend_xon_q  <= pend_xon_d;
      pend_xoff_q <= pend_xoff_d;
      brk_pend_q  <= brk_pend_d;
      brk_cnt_q   <= brk_cnt_d;
    end
  end

  assign tx_wr     = tx_wr_q;
  assign tx_din    = tx_din_q;
  assign txBreak   = txbreak_q;
  assign paused    = paused_q;
  assign xoff_sent = xoff_sent_q;

endmodule

// File: tb/tb_uart6551_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart6551_tx_sched
//
// Directed bench for uart6551_tx_sched. Inputs change on the falling clock
// edge; outputs are observed on the falling edge (or 1 ns after it for the
// combinational h_ready). A monitor logs every transmitter write with its
// cycle number so ordering, data and spacing can be checked afterwards.
// ---------------------------------------------------------------------------
module tb_uart6551_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud16x_ce = 1'b0;
  logic       sw_flow_en;
  logic       rx_xoff_seen;
  logic       rx_xon_seen;
  logic       rx_hi;
  logic       rx_lo;
  logic       h_valid;
  logic [7:0] h_data;
  logic       h_ready;
  logic       brk_req;
  logic       brk_busy;
  logic       tx_wr;
  logic [7:0] tx_din;
  logic       tx_full;
  logic       tx_empty;
  logic       txBreak;
  logic       paused;
  logic       xoff_sent;

  uart6551_tx_sched dut (
    .clk          (clk),
    .rst          (rst),
    .baud16x_ce   (baud16x_ce),
    .sw_flow_en   (sw_flow_en),
    .rx_xoff_seen (rx_xoff_seen),
    .rx_xon_seen  (rx_xon_seen),
    .rx_hi        (rx_hi),
    .rx_lo        (rx_lo),
    .h_valid      (h_valid),
    .h_data       (h_data),
    .h_ready      (h_ready),
    .brk_req      (brk_req),
    .brk_busy     (brk_busy),
    .tx_wr        (tx_wr),
    .tx_din       (tx_din),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .txBreak      (txBreak),
    .paused       (paused),
    .xoff_sent    (xoff_sent)
  );

  always #5 clk = ~clk;

  // Baud x16 enable: one cycle in every four.
  int ce_div = 0;
  always @(negedge clk) begin
    ce_div     = ce_div + 1;
    baud16x_ce = ((ce_div % 4) == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Ticks seen by the DUT while the break output is asserted.
  int brk_ticks = 0;
  always @(posedge clk) if (baud16x_ce && txBreak) brk_ticks = brk_ticks + 1;

  // Write log.
  logic [7:0] wr_data[$];
  int         wr_cyc[$];
  int         wr_wide = 0;
  logic       wr_prev = 1'b0;
  always @(negedge clk) begin
    if (tx_wr) begin
      wr_data.push_back(tx_din);
      wr_cyc.push_back(cyc);
      if (wr_prev) wr_wide = wr_wide + 1;
    end
    wr_prev = tx_wr;
  end

  function automatic logic [31:0] wr_at(input int i);
    if (i < wr_data.size()) return {24'd0, wr_data[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] cyc_at(input int i);
    if (i < wr_cyc.size()) return wr_cyc[i];
    return 32'hDEAD_BEEF;
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a byte and wait (bounded) for the handshake; returns on a falling
  // edge after the accepting rising edge, with h_valid dropped.
  task automatic send_byte(input logic [7:0] d);
    bit done;
    done    = 1'b0;
    h_valid = 1'b1;
    h_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      #1;
      if (h_ready) done = 1'b1;
      @(negedge clk);
    end
    h_valid = 1'b0;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  int n0;
  int t0;

  initial begin
    rst          = 1'b1;
    sw_flow_en   = 1'b0;
    rx_xoff_seen = 1'b0;
    rx_xon_seen  = 1'b0;
    rx_hi        = 1'b0;
    rx_lo        = 1'b0;
    h_valid      = 1'b0;
    h_data       = 8'h00;
    brk_req      = 1'b0;
    tx_full      = 1'b0;
    tx_empty     = 1'b1;

    // ---------------- reset state
    idle_cycles(3);
    check("rst_tx_wr",     {31'd0, tx_wr},     32'd0);
    check("rst_tx_din",    {24'd0, tx_din},    32'h00);
    check("rst_txBreak",   {31'd0, txBreak},   32'd0);
    check("rst_paused",    {31'd0, paused},    32'd0);
    check("rst_xoff_sent", {31'd0, xoff_sent}, 32'd0);
    check("rst_brk_busy",  {31'd0, brk_busy},  32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 check("rst_h_ready", {31'd0, h_ready}, 32'd1);
    @(negedge clk);

    // ---------------- back-to-back host bytes
    n0 = wr_data.size();
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle_cycles(6);
    check("stream_count", wr_data.size() - n0, 32'd2);
    check("stream_d0",    wr_at(n0),           32'hA5);
    check("stream_d1",    wr_at(n0 + 1),       32'h3C);
    check("stream_space", cyc_at(n0 + 1) - cyc_at(n0), 32'd3);

    // ---------------- tx_full holds off the host
    n0      = wr_data.size();
    tx_full = 1'b1;
    h_valid = 1'b1;
    h_data  = 8'h5A;
    idle_cycles(5);
    #1 check("full_h_ready", {31'd0, h_ready}, 32'd0);
    check("full_no_wr", wr_data.size() - n0, 32'd0);
    @(negedge clk);
    tx_full = 1'b0;
    send_byte(8'h5A);
    idle_cycles(4);
    check("full_release_count", wr_data.size() - n0, 32'd1);
    check("full_release_data",  wr_at(n0),           32'h5A);

    // ---------------- local XOFF ahead of waiting host byte, then XON
    sw_flow_en = 1'b1;
    tx_full    = 1'b1;
    h_valid    = 1'b1;
    h_data     = 8'h77;
    rx_hi      = 1'b1;
    @(negedge clk);
    rx_hi = 1'b0;
    @(negedge clk);
    check("xoff_not_yet", {31'd0, xoff_sent}, 32'd0);
    n0      = wr_data.size();
    tx_full = 1'b0;
    #1 check("pend_blocks_host", {31'd0, h_ready}, 32'd0);
    send_byte(8'h77);
    idle_cycles(4);
    check("xoff_count", wr_data.size() - n0, 32'd2);
    check("xoff_char",  wr_at(n0),           32'h13);
    check("xoff_host",  wr_at(n0 + 1),       32'h77);
    check("xoff_sent1", {31'd0, xoff_sent},  32'd1);
    n0    = wr_data.size();
    rx_lo = 1'b1;
    @(negedge clk);
    rx_lo = 1'b0;
    idle_cycles(5);
    check("xon_count",  wr_data.size() - n0, 32'd1);
    check("xon_char",   wr_at(n0),           32'h11);
    check("xon_sent0",  {31'd0, xoff_sent},  32'd0);

    // ---------------- remote pause
    rx_xoff_seen = 1'b1;
    @(negedge clk);
    rx_xoff_seen = 1'b0;
    #1 check("paused_set", {31'd0, paused}, 32'd1);
    n0      = wr_data.size();
    h_valid = 1'b1;
    h_data  = 8'h42;
    idle_cycles(4);
    #1 check("paused_h_ready", {31'd0, h_ready}, 32'd0);
    @(negedge clk);
    rx_xoff_seen = 1'b1;
    rx_xon_seen  = 1'b1;
    @(negedge clk);
    rx_xoff_seen = 1'b0;
    rx_xon_seen  = 1'b0;
    #1 check("paused_both_hold", {31'd0, paused}, 32'd1);
    @(negedge clk);
    rx_hi = 1'b1;
    @(negedge clk);
    rx_hi = 1'b0;
    idle_cycles(5);
    check("paused_ctrl_count", wr_data.size() - n0, 32'd1);
    check("paused_ctrl_char",  wr_at(n0),           32'h13);
    check("paused_xoff_sent",  {31'd0, xoff_sent},  32'd1);
    rx_xon_seen = 1'b1;
    @(negedge clk);
    rx_xon_seen = 1'b0;
    #1 check("paused_clear", {31'd0, paused}, 32'd0);
    @(negedge clk);
    send_byte(8'h42);
    idle_cycles(4);
    check("resume_data", wr_at(n0 + 1), 32'h42);

    // ---------------- disabling flow control
    sw_flow_en = 1'b0;
    @(negedge clk);
    #1 check("disable_xoff_sent", {31'd0, xoff_sent}, 32'd0);
    @(negedge clk);
    rx_xoff_seen = 1'b1;
    @(negedge clk);
    rx_xoff_seen = 1'b0;
    #1 check("disable_ignore_xoff", {31'd0, paused}, 32'd0);
    @(negedge clk);

    // ---------------- timed break with drain
    n0       = wr_data.size();
    tx_empty = 1'b0;
    brk_req  = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    #1 check("brk_busy_set", {31'd0, brk_busy}, 32'd1);
    idle_cycles(10);
    #1 check("brk_drain_hold", {31'd0, txBreak}, 32'd0);
    check("brk_drain_busy", {31'd0, brk_busy}, 32'd1);
    check("brk_h_ready",    {31'd0, h_ready},  32'd0);
    t0       = brk_ticks;
    tx_empty = 1'b1;
    for (int i = 0; i < 20 && !txBreak; i++) @(negedge clk);
    check("brk_start", {31'd0, txBreak}, 32'd1);
    @(negedge clk);
    brk_req = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    for (int i = 0; i < 2000 && txBreak; i++) @(negedge clk);
    check("brk_end", {31'd0, txBreak}, 32'd0);
    #1 check("brk_busy_clear", {31'd0, brk_busy}, 32'd0);
    check("brk_ticks", brk_ticks - t0, 32'd160);
    idle_cycles(20);
    check("brk_second_ignored", {31'd0, txBreak}, 32'd0);
    check("brk_no_writes", wr_data.size() - n0, 32'd0);

    // ---------------- reset in the middle of a break
    brk_req = 1'b1;
    @(negedge clk);
    brk_req = 1'b0;
    for (int i = 0; i < 20 && !txBreak; i++) @(negedge clk);
    check("brk2_start", {31'd0, txBreak}, 32'd1);
    idle_cycles(10);
    #2 rst = 1'b1;
    #1 check("rst_brk_txBreak", {31'd0, txBreak},  32'd0);
    check("rst_brk_busy",       {31'd0, brk_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n0  = wr_data.size();
    idle_cycles(20);
    check("post_rst_txBreak", {31'd0, txBreak}, 32'd0);
    check("post_rst_no_wr",   wr_data.size() - n0, 32'd0);

    // ---------------- reset in the middle of a write
    h_valid = 1'b1;
    h_data  = 8'h99;
    for (int i = 0; i < 20 && !tx_wr; i++) @(negedge clk);
    check("wr_seen", {31'd0, tx_wr}, 32'd1);
    #2 rst = 1'b1;
    h_valid = 1'b0;
    #1 check("rst_wr_tx_wr", {31'd0, tx_wr},  32'd0);
    check("rst_wr_tx_din",   {24'd0, tx_din}, 32'h00);
    @(negedge clk);
    rst = 1'b0;
    n0  = wr_data.size();
    idle_cycles(10);
    check("post_rst_wr_none", wr_data.size() - n0, 32'd0);

    check("wr_width", wr_wide, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart6551_tx_sched.md
UART6551_TX_SCHED -- requirements
Module: uart6551_tx_sched

Interface
REQ-001 The block SHALL have parameter XON_CHAR, default 8'h11, the XON character sent to resume the remote transmitter.
REQ-002 The block SHALL have parameter XOFF_CHAR, default 8'h13, the XOFF character sent to pause the remote transmitter.
REQ-003 The block SHALL have parameter BRK_LEN, default 16'd160, the break duration in baud16x_ce ticks.
REQ-004 The block SHALL have these ports:
- clk  in  1  clock; the only clock
- rst  in  1  asynchronous, active-high reset
- baud16x_ce  in  1  baud x16 clock enable
- sw_flow_en  in  1  enables XON/XOFF flow control
- rx_xoff_seen  in  1  one-cycle pulse: remote sent XOFF
- rx_xon_seen  in  1  one-cycle pulse: remote sent XON
- rx_hi  in  1  local receive FIFO above high watermark
- rx_lo  in  1  local receive FIFO below low watermark
- h_valid  in  1  host byte valid
- h_data  in  8  host byte
- h_ready  out  1  host byte accepted when h_valid & h_ready
- brk_req  in  1  one-cycle pulse: request a timed break
- brk_busy  out  1  a break is pending or in progress
- tx_wr  out  1  write strobe to the transmitter
- tx_din  out  8  byte to the transmitter
- tx_full  in  1  transmitter FIFO full
- tx_empty  in  1  transmitter FIFO empty
- txBreak  out  1  break control to the transmitter
- paused  out  1  remote XOFF in effect
- xoff_sent  out  1  local XOFF sent and not yet cancelled

Function
REQ-005 The FSM SHALL have these states: IDLE, WR, GAP, BRK_DRAIN and BRK.
REQ-006 Each write SHALL be IDLE (decision) -> WR (tx_wr=1 for exactly one cycle) -> GAP (tx_wr=0 for one cycle) -> IDLE, so there are always at least 3 cycles between tx_wr rising edges; this guarantees the transmitter's write edge detector sees each write.
REQ-007 tx_din SHALL be registered in IDLE at the decision, and SHALL hold stable through WR and GAP.
REQ-008 In IDLE, priority SHALL be break > control character > host byte, evaluated every cycle.
REQ-009 Break: when brk_pend=1, go to BRK_DRAIN; wait for tx_empty=1; then go to BRK with txBreak=1.
REQ-010 In BRK, a 16-bit counter SHALL count baud16x_ce ticks; when count==BRK_LEN-1 on a tick, clear txBreak, clear brk_pend and go to IDLE.
REQ-011 brk_pend SHALL be set by brk_req; brk_req while brk_busy=1 SHALL be ignored; brk_busy = brk_pend | (state in BRK_DRAIN, BRK).
REQ-012 Control request: when sw_flow_en=1, rx_hi=1 and xoff_sent=0, latch pend_xoff.
REQ-013 When sw_flow_en=1, rx_lo=1 and xoff_sent=1, latch pend_xon.
REQ-014 Only one control request SHALL be pending at a time; a new request overwrites the pending one.
REQ-015 A control character SHALL be issued from IDLE only if tx_full=0; it SHALL ignore paused.
REQ-016 Issuing XOFF SHALL set xoff_sent; issuing XON SHALL clear it; the pending flag SHALL clear when the state enters WR.
REQ-017 h_ready = (state==IDLE) & ~tx_full & ~paused & ~brk_pend & ~pend_xon & ~pend_xoff.
REQ-018 On a host transfer, tx_din <= h_data and the next state SHALL be WR; tx_wr SHALL rise the cycle after acceptance.
REQ-019 paused SHALL be set by rx_xoff_seen and cleared by rx_xon_seen; both in the same cycle SHALL leave paused unchanged; both pulses SHALL be ignored when sw_flow_en=0.
REQ-020 sw_flow_en=0 SHALL synchronously clear paused, xoff_sent, pend_xon and pend_xoff; it SHALL NOT abort WR/GAP or a break.
REQ-021 tx_full rising during WR or GAP SHALL NOT cancel the write in flight; it is checked only in IDLE.
REQ-022 BRK_LEN=0 SHALL be treated as 1 tick.

Reset
REQ-023 rst SHALL asynchronously force: state=IDLE, tx_wr=0, tx_din=8'h00, txBreak=0, paused=0, xoff_sent=0, brk_busy=0, all pending flags=0, break counter=0; h_ready then follows REQ-017.
REQ-024 rst asserted mid-break or mid-write SHALL abort immediately with no further tx_wr pulse after release until a new request.

Verification
REQ-025 Host streams 8'hA5, 8'h3C back-to-back, tx_full=0 -> tx_wr pulses 3 cycles apart with tx_din=A5 then 3C; each tx_wr is one cycle wide.
REQ-026 sw_flow_en=1, pulse rx_hi while h_valid=1 -> XOFF_CHAR (8'h13) is written before the host byte and xoff_sent=1; then pulse rx_lo -> 8'h11 is written and xoff_sent=0.
REQ-027 rx_xoff_seen pulse -> paused=1 and h_ready=0 while XON/XOFF can still be sent; rx_xon_seen -> host traffic resumes.
REQ-028 brk_req with tx_empty=0 -> state holds in BRK_DRAIN; tx_empty=1 -> txBreak=1 for exactly 160 baud16x_ce ticks; a second brk_req during the break is ignored.
REQ-029 tx_full=1 with h_valid=1 -> no tx_wr pulse and h_ready=0; tx_full falls -> the byte is accepted.
REQ-030 Assert rst during BRK -> txBreak=0 and brk_busy=0 immediately, with no clock edge required.
